// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, opcode encodings and the
// fetch-stage state encoding.
package risc_toy_pkg;

  localparam int XLEN  = 32;
  localparam int IAW   = 30;
  localparam int IFQ_W = XLEN + IAW;

  typedef enum logic [4:0] {
    OP_ADDI = 5'd0,
    OP_ANDI = 5'd1,
    OP_ORI  = 5'd2,
    OP_MOVI = 5'd3,
    OP_ADD  = 5'd4,
    OP_SUB  = 5'd5,
    OP_NEG  = 5'd6,
    OP_NOT  = 5'd7,
    OP_AND  = 5'd8,
    OP_OR   = 5'd9,
    OP_XOR  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_SHL  = 5'd13,
    OP_ROR  = 5'd14,
    OP_BR   = 5'd15,
    OP_BRL  = 5'd16,
    OP_J    = 5'd17,
    OP_JL   = 5'd18,
    OP_LD   = 5'd19,
    OP_LDR  = 5'd20,
    OP_ST   = 5'd21,
    OP_STR  = 5'd22
  } opcode_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/risc_toy_fetch_ifq_fifo.sv
// Prefetch queue for the fetch stage: synchronous FIFO with flush and an
// occupancy output; the head is forced to zero while the queue is empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 62
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      level_r;
  logic             push_s;
  logic             pop_s;

  assign pop_s  = pop && (level_r != {(PW+1){1'b0}});
  assign push_s = push && ((level_r != LVL_FULL) || pop_s);

  // Entry storage; reads are qualified by head_valid so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s && !flush && !RST) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; flush behaves like reset for the bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (PW+1)'(1'b1);
        2'b01:   level_r <= level_r - (PW+1)'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head_valid = (level_r != {(PW+1){1'b0}});
  assign head_data  = head_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign level      = level_r;

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: PC generation, one-outstanding memory
// request, prefetch queue toward decode. Optional macro: IFQ_BYPASS_EN.
module risc_toy_fetch
  import risc_toy_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   IREQ,
  output logic [IAW-1:0]         IADDR,
  input  logic [XLEN-1:0]        INSTR,
  output logic                   ID_VALID,
  input  logic                   ID_READY,
  output logic [XLEN-1:0]        ID_INSTR,
  output logic [IAW-1:0]         ID_IADDR,
  input  logic                   REDIRECT,
  input  logic [IAW-1:0]         REDIRECT_ADDR,
  output logic [$clog2(DEPTH):0] IFQ_LEVEL
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW:0] CREDIT_LIM = (LW+1)'(DEPTH);

  fetch_state_e   state_r;
  fetch_state_e   state_nxt_s;
  logic [IAW-1:0] pc_r;
  logic           pend_r;
  logic [IAW-1:0] pend_addr_r;
  logic           issue_s;
  logic           credit_s;
  logic [LW:0]    occ_s;
  logic           ret_s;
  logic           push_s;
  logic           pop_s;
  logic           fifo_valid_s;
  logic [IFQ_W-1:0] fifo_head_s;
  logic [LW-1:0]  level_s;

  // A request in flight reserves a slot, so a return never meets a full queue.
  assign occ_s    = {1'b0, level_s} + {{LW{1'b0}}, pend_r};
  assign credit_s = (occ_s < CREDIT_LIM);
  assign ret_s    = pend_r && !REDIRECT;
  assign pop_s    = fifo_valid_s && ID_READY;

  // Next-state and issue decision; reset and redirect override the FSM.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    if (RST) begin
      state_nxt_s = S_BOOT;
      issue_s     = 1'b0;
    end else if (REDIRECT) begin
      state_nxt_s = S_FETCH;
      issue_s     = 1'b0;
    end else begin
      case (state_r)
        S_BOOT: begin
          state_nxt_s = S_FETCH;
        end
        S_FETCH: begin
          if (credit_s) begin
            issue_s     = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            issue_s     = 1'b0;
            state_nxt_s = S_HOLD;
          end
        end
        S_HOLD: begin
          if (credit_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_HOLD;
          end
        end
        default: begin
          state_nxt_s = S_BOOT;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC and the single outstanding request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r        <= RESET_PC;
      pend_r      <= 1'b0;
      pend_addr_r <= 30'h0;
    end else begin
      pend_r <= issue_s;
      if (REDIRECT) begin
        pc_r <= REDIRECT_ADDR;
      end else if (issue_s) begin
        pc_r        <= pc_r + 30'd1;
        pend_addr_r <= pc_r;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

`ifdef IFQ_BYPASS_EN
  logic byp_s;
  assign byp_s  = ret_s && !fifo_valid_s;
  assign push_s = ret_s && !(byp_s && ID_READY);

  // Empty queue: the arriving return is shown to decode in the same cycle.
  always_comb begin
    ID_VALID = fifo_valid_s || byp_s;
    ID_INSTR = {XLEN{1'b0}};
    ID_IADDR = {IAW{1'b0}};
    if (fifo_valid_s) begin
      ID_INSTR = fifo_head_s[IFQ_W-1:IAW];
      ID_IADDR = fifo_head_s[IAW-1:0];
    end else if (byp_s) begin
      ID_INSTR = INSTR;
      ID_IADDR = pend_addr_r;
    end else begin
      ID_INSTR = {XLEN{1'b0}};
      ID_IADDR = {IAW{1'b0}};
    end
  end
`else
  assign push_s   = ret_s;
  assign ID_VALID = fifo_valid_s;
  assign ID_INSTR = fifo_head_s[IFQ_W-1:IAW];
  assign ID_IADDR = fifo_head_s[IAW-1:0];
`endif

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IFQ_W)
  ) u_ifq (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push_s),
    .push_data  ({INSTR, pend_addr_r}),
    .pop        (pop_s),
    .flush      (REDIRECT),
    .head_valid (fifo_valid_s),
    .head_data  (fifo_head_s),
    .level      (level_s)
  );

  assign IREQ      = issue_s;
  assign IADDR     = pc_r;
  assign IFQ_LEVEL = level_s;

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Self-checking bench for risc_toy_fetch (default build): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_risc_toy_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR = 32'h0;
  logic        ID_VALID;
  logic        ID_READY = 1'b0;
  logic [31:0] ID_INSTR;
  logic [29:0] ID_IADDR;
  logic        REDIRECT = 1'b0;
  logic [29:0] REDIRECT_ADDR = 30'h0;
  logic [2:0]  IFQ_LEVEL;

  always #5 CLK = ~CLK;

  risc_toy_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_INSTR(ID_INSTR),
    .ID_IADDR(ID_IADDR), .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
    .IFQ_LEVEL(IFQ_LEVEL)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued {instr, addr} pairs, one outstanding request, fetch PC.
  logic [61:0] mq[$];
  bit          m_pend = 1'b0;
  bit          m_known = 1'b0;
  logic [29:0] m_pend_addr = 30'h0;
  logic [29:0] m_pc = 30'h0;
  int          stall = 0;

  logic        o_ireq, o_valid, o_took;
  logic [29:0] o_iaddr, o_id_iaddr;
  logic [31:0] o_id_instr;
  logic [2:0]  o_lvl;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h1000_0000 + {2'b00, a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance model.
  task automatic step(input bit rst, input bit redir, input logic [29:0] raddr, input bit rdy);
    logic [31:0] instr_v;
    logic [61:0] head;
    int sz;
    bit credit;
    RST = rst;
    REDIRECT = redir;
    REDIRECT_ADDR = raddr;
    ID_READY = rdy;
    instr_v = m_pend ? mem_word(m_pend_addr) : 32'($urandom());
    INSTR = instr_v;
    @(negedge CLK);
    o_ireq = IREQ;
    o_iaddr = IADDR;
    o_valid = ID_VALID;
    o_id_instr = ID_INSTR;
    o_id_iaddr = ID_IADDR;
    o_lvl = IFQ_LEVEL;
    o_took = ID_VALID && rdy;
    sz = mq.size();
    credit = (sz + int'(m_pend)) < DEPTH;
    if (m_known) begin
      check_eq("ifq_level", 64'(IFQ_LEVEL), 64'(sz));
      check_eq("id_valid", 64'(ID_VALID), 64'(sz != 0));
      if (sz != 0) begin
        head = mq[0];
        check_eq("id_instr", 64'(ID_INSTR), 64'(head[61:30]));
        check_eq("id_iaddr", 64'(ID_IADDR), 64'(head[29:0]));
      end
      check_eq("iaddr", 64'(IADDR), 64'(m_pc));
      if (IREQ) begin
        check_eq("ireq_allowed", 64'(!redir && !rst && credit), 64'd1);
      end
      if (!rst && !redir && credit && !IREQ) stall++;
      else stall = 0;
      check_eq("fetch_stall", 64'(stall < 3), 64'd1);
    end
    if (rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc = RESET_PC;
      m_pend_addr = 30'h0;
      m_known = 1'b1;
      stall = 0;
    end else if (redir) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc = raddr;
    end else begin
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (m_pend) mq.push_back({instr_v, m_pend_addr});
      m_pend = o_ireq;
      if (o_ireq) begin
        m_pend_addr = m_pc;
        m_pc = m_pc + 30'd1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 30'h0, 1'b1);
    step(1'b1, 1'b1, 30'h3, 1'b1);
  endtask

  initial begin
    int cnt;
    bit got, seen20, found;
    logic [29:0] first_addr;
    logic [29:0] popped[$];

    // Reset release with decode always ready.
    do_reset();
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("c0_ireq", 64'(o_ireq), 64'd0);
    check_eq("c0_iaddr", 64'(o_iaddr), 64'(RESET_PC));
    check_eq("c0_id_instr", 64'(o_id_instr), 64'd0);
    check_eq("c0_id_iaddr", 64'(o_id_iaddr), 64'd0);
    check_eq("c0_level", 64'(o_lvl), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("c1_ireq", 64'(o_ireq), 64'd1);
    check_eq("c1_iaddr", 64'(o_iaddr), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("c2_iaddr", 64'(o_iaddr), 64'd1);
    check_eq("c2_id_valid", 64'(o_valid), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("c3_id_valid", 64'(o_valid), 64'd1);
    check_eq("c3_id_instr", 64'(o_id_instr), 64'h1000_0000);
    check_eq("c3_id_iaddr", 64'(o_id_iaddr), 64'd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 30'h0, 1'b1);
      check_eq("stream_valid", 64'(o_valid), 64'd1);
      check_eq("stream_addr", 64'(o_id_iaddr), 64'(k + 1));
    end

    // Decode stalled: queue fills to DEPTH then drains in order.
    do_reset();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 30'h0, 1'b0);
      cnt += int'(o_ireq);
    end
    check_eq("full_req_count", 64'(cnt), 64'd4);
    check_eq("full_level", 64'(o_lvl), 64'd4);
    got = 1'b0;
    first_addr = 30'h0;
    popped.delete();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 30'h0, 1'b1);
      if (o_took) popped.push_back(o_id_iaddr);
      if (o_ireq && !got) begin
        got = 1'b1;
        first_addr = o_iaddr;
      end
    end
    check_eq("resume_seen", 64'(got), 64'd1);
    check_eq("resume_addr", 64'(first_addr), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_order", 64'(popped.size() > k ? popped[k] : 30'h3FFF_FFFF), 64'(k));
    end

    // Redirect with three queued entries and a return in flight.
    do_reset();
    for (int k = 0; k < 20 && !(mq.size() == 3 && m_pend); k++) step(1'b0, 1'b0, 30'h0, 1'b0);
    check_eq("redir_setup", 64'(mq.size() == 3 && m_pend), 64'd1);
    step(1'b0, 1'b1, 30'h100, 1'b0);
    check_eq("redir_ireq", 64'(o_ireq), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("redir_t1_level", 64'(o_lvl), 64'd0);
    check_eq("redir_t1_ireq", 64'(o_ireq), 64'd1);
    check_eq("redir_t1_iaddr", 64'(o_iaddr), 64'h100);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("redir_t2_valid", 64'(o_valid), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("redir_t3_valid", 64'(o_valid), 64'd1);
    check_eq("redir_t3_addr", 64'(o_id_iaddr), 64'h100);
    check_eq("redir_t3_instr", 64'(o_id_instr), 64'(mem_word(30'h100)));

    // Back-to-back redirects: the second target wins.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 30'h0, 1'b1);
    step(1'b0, 1'b1, 30'h20, 1'b1);
    step(1'b0, 1'b1, 30'h40, 1'b1);
    check_eq("b2b_ireq", 64'(o_ireq), 64'd0);
    seen20 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 30'h0, 1'b1);
      if (o_ireq && o_iaddr == 30'h20) seen20 = 1'b1;
      if (o_valid && !found) begin
        found = 1'b1;
        check_eq("b2b_first_addr", 64'(o_id_iaddr), 64'h40);
        check_eq("b2b_latency", 64'(k), 64'd2);
      end
    end
    check_eq("b2b_found", 64'(found), 64'd1);
    check_eq("b2b_no_0x20", 64'(seen20), 64'd0);

    // PC wrap at the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("wrap_iaddr0", 64'(o_iaddr), 64'h3FFF_FFFF);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("wrap_iaddr1", 64'(o_iaddr), 64'h0);
    popped.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 30'h0, 1'b1);
      if (o_took) popped.push_back(o_id_iaddr);
    end
    check_eq("wrap_pop0", 64'(popped.size() > 0 ? popped[0] : 30'h1), 64'h3FFF_FFFF);
    check_eq("wrap_pop1", 64'(popped.size() > 1 ? popped[1] : 30'h1), 64'h0);

    // Reset mid-stream, colliding with a redirect.
    do_reset();
    for (int k = 0; k < 20 && mq.size() != 2; k++) step(1'b0, 1'b0, 30'h0, 1'b0);
    check_eq("rst_setup", 64'(mq.size()), 64'd2);
    step(1'b1, 1'b1, 30'h55, 1'b1);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("rst_ireq", 64'(o_ireq), 64'd0);
    check_eq("rst_iaddr", 64'(o_iaddr), 64'(RESET_PC));
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_id_instr", 64'(o_id_instr), 64'd0);
    check_eq("rst_id_iaddr", 64'(o_id_iaddr), 64'd0);
    check_eq("rst_level", 64'(o_lvl), 64'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    check_eq("rst_restart", 64'(o_ireq), 64'd1);
    check_eq("rst_restart_addr", 64'(o_iaddr), 64'(RESET_PC));

    // Randomized traffic; decode readiness varies by phase.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = int'($urandom_range(0, 100));
      for (int k = 0; k < 200; k++) begin
        int r;
        bit rs, rd;
        logic [29:0] ra;
        r  = int'($urandom_range(0, 999));
        rs = (r < 4);
        rd = !rs && (r < 40);
        case ($urandom_range(0, 2))
          0:       ra = 30'($urandom());
          1:       ra = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
          default: ra = 30'($urandom_range(0, 255));
        endcase
        step(rs, rd, ra, int'($urandom_range(0, 99)) < rdy_pct);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_toy_fetch.md
# risc_toy_fetch

Instruction-fetch stage of the RISC_TOY pipeline: generates word addresses toward instruction memory, captures returned instructions into a small prefetch queue, and presents them with their word address to the decode stage over a valid/ready handshake. Taken branches/jumps from execute redirect the fetch PC and flush all fetched-but-undecoded work. It sits between the instruction-memory port (IREQ/IADDR/INSTR) and the decode stage.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, ≥ 2.
- RESET_PC, 30'h0: word address fetched first after reset.

- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IREQ  out  1  instruction fetch request this cycle.
- IADDR  out  30  word address of request; holds fetch PC when IREQ=0.
- INSTR  in  32  instruction data, valid the cycle after IREQ.
- ID_VALID  out  1  queue head valid toward decode.
- ID_READY  in  1  decode accepts head this cycle.
- ID_INSTR  out  32  head instruction.
- ID_IADDR  out  30  head word address.
- REDIRECT  in  1  taken BR/BRL/J/JL from execute.
- REDIRECT_ADDR  in  30  target word address.
- IFQ_LEVEL  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- FSM states: S_BOOT, S_FETCH, S_HOLD. Reset → S_BOOT. S_BOOT → S_FETCH unconditionally. S_FETCH → S_HOLD when credit exhausted; S_HOLD → S_FETCH when credit available. REDIRECT from any non-reset state → S_FETCH.
- Credit: level + pending < DEPTH, where pending = IREQ of previous cycle (one outstanding at most).
- Issue: in S_FETCH with credit and REDIRECT=0: IREQ=1, IADDR=fetch PC, fetch PC ← PC+1 modulo 2^30 (3FFF_FFFF wraps to 0).
- Return: if pending and REDIRECT=0, push {INSTR, pending address} into queue.
- Pop: ID_VALID & ID_READY removes head. Simultaneous push and pop: level unchanged, order preserved. Credit accounting guarantees no push to a full queue.
- REDIRECT: queue emptied, return arriving this cycle discarded, IREQ=0 this cycle, fetch PC ← REDIRECT_ADDR. A pop in the same cycle is permitted and has no further effect. Back-to-back REDIRECTs: last one wins.
- RST dominates REDIRECT and all handshakes; reset mid-stream discards queue and pending return.
- Reset values: IREQ=0, IADDR=RESET_PC, ID_VALID=0, ID_INSTR=0, ID_IADDR=0, IFQ_LEVEL=0.

## Timing
- Cycle 0 = first cycle with RST=0: S_BOOT, IREQ=0.
- Cycle 1: IREQ=1, IADDR=RESET_PC. Cycle 2: INSTR sampled, pushed. Cycle 3: ID_VALID=1.
- Request-to-ID_VALID latency: 2 cycles. REDIRECT at cycle t: IREQ with target at t+1, ID_VALID at t+3.
- With ID_READY held high, steady throughput of one instruction per cycle.
- ID_VALID/ID_INSTR/ID_IADDR driven from registers; no combinational path from ID_READY or REDIRECT to them.

## Configuration
- IFQ_BYPASS_EN defined: when queue is empty and a return is being accepted, the return is presented on ID_VALID/ID_INSTR/ID_IADDR in the same cycle; if ID_READY=1 it is consumed without entering the queue. Request-to-valid latency 1; REDIRECT-to-valid 2. Combinational INSTR→ID_* path exists.
- Not defined: all outputs registered, latencies as in Timing.

## Structure
- Shared package risc_toy_pkg: XLEN=32, IAW=30, opcode constants (ADDI … STR), FSM state encoding for this block.
- One sub-module: ifq_fifo (synchronous FIFO, DEPTH entries of 62 bits, push/pop/flush, level output). Fetch PC, pending flag and FSM stay in risc_toy_fetch.

## Test plan
- Reset release, ID_READY=1, memory returns 32'h1000_0000+addr -> IADDR 0,1,2,… from cycle 1; ID_VALID at cycle 3 with ID_INSTR 32'h1000_0000, ID_IADDR 0; then one per cycle in order.
- ID_READY=0 from cycle 0, DEPTH=4 -> exactly 4 requests (addr 0–3), IREQ=0 afterwards, IFQ_LEVEL=4; release ID_READY -> entries 0–3 drained in order, fetch resumes at addr 4.
- REDIRECT=1, REDIRECT_ADDR=30'h100 while IFQ_LEVEL=3 and return pending -> IFQ_LEVEL=0 next cycle, pending return never seen, IREQ with 30'h100 at t+1, ID_IADDR 30'h100 at t+3.
- REDIRECT on two consecutive cycles to 30'h20 then 30'h40 -> no fetch from 30'h20; first ID_IADDR is 30'h40.
- Fetch PC at 30'h3FFF_FFFF -> next IADDR 0; ID_IADDR sequence 3FFF_FFFF, 0.
- RST asserted for one cycle with IFQ_LEVEL=2 and REDIRECT=1 -> all outputs at reset values next cycle, fetch restarts at RESET_PC.
